// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - IF/DM arbiter serialising accesses onto one single-ported memory
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin grant on contention; fixed DM priority otherwise)
module memory_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Access cycles beyond the first; the counter is 4 bits wide, so 0..15 is the legal range.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;   // 0 = IF, 1 = DM; doubles as last_owner
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_dm;

`ifdef ARB_ROUND_ROBIN_EN
  // Round robin: on contention the requester that did not own the last grant wins
  always_comb begin
    grant_dm = dm_req;
    if (if_req && dm_req) begin
      grant_dm = ~owner_q;
    end
  end
`else
  // Fixed priority: DM wins whenever it requests
  always_comb begin
    grant_dm = dm_req;
  end
`endif

  // Next-state logic: grant and latch in IDLE, count wait states in ACCESS, one-cycle RESP
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          owner_d = grant_dm;
          addr_d  = grant_dm ? dm_addr : if_addr;
          we_d    = grant_dm & dm_we;
          wdata_d = grant_dm ? dm_wdata : '0;
          cnt_d   = CNT_INIT;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (owner_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              if_rdata_d = mem_rdata;
            end
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-access registers; reset drops any access in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Strobes decode straight from state so they fall the moment reset asserts
  always_comb begin
    mem_en    = (state_q == ST_ACCESS);
    mem_we    = (state_q == ST_ACCESS) & we_q;
    if_ack    = (state_q == ST_RESP) & ~owner_q;
    dm_ack    = (state_q == ST_RESP) & owner_q;
    busy      = (state_q != ST_IDLE);
    owner     = owner_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - scoreboard bench for memory_port_arbiter (WAIT_STATES 1, 0, 15)
module tb_memory_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NI = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic          if_req    [NI];
  logic [AW-1:0] if_addr   [NI];
  logic [DW-1:0] if_rdata  [NI];
  logic          if_ack    [NI];
  logic          dm_req    [NI];
  logic          dm_we     [NI];
  logic [AW-1:0] dm_addr   [NI];
  logic [DW-1:0] dm_wdata  [NI];
  logic [DW-1:0] dm_rdata  [NI];
  logic          dm_ack    [NI];
  logic          mem_en    [NI];
  logic          mem_we    [NI];
  logic [AW-1:0] mem_addr  [NI];
  logic [DW-1:0] mem_wdata [NI];
  logic [DW-1:0] mem_rdata [NI];
  logic          busy      [NI];
  logic          owner     [NI];

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    memory_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_rdata (if_rdata[g]),
      .if_ack   (if_ack[g]),
      .dm_req   (dm_req[g]),
      .dm_we    (dm_we[g]),
      .dm_addr  (dm_addr[g]),
      .dm_wdata (dm_wdata[g]),
      .dm_rdata (dm_rdata[g]),
      .dm_ack   (dm_ack[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g]),
      .owner    (owner[g])
    );
    assign mem_rdata[g] = mem_val(mem_addr[g]);
  end

  typedef struct {
    logic          dm;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  logic          mdl_last  = 1'b0;
  logic [DW-1:0] exp_if_rd = '0;
  logic [DW-1:0] exp_dm_rd = '0;
  int            checks    = 0;
  int            failures  = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input logic dm, input logic we, input logic [AW-1:0] a,
                                   input logic [DW-1:0] wd);
    exp_t e;
    e.dm   = dm;
    e.we   = we;
    e.addr = a;
    e.data = we ? wd : mem_val(a);
    sb_q.push_back(e);
    mdl_last = dm;
  endfunction

  // Winner when both requesters are pending: 1 = DM
  function automatic logic pick_both();
`ifdef ARB_ROUND_ROBIN_EN
    return ~mdl_last;
`else
    return 1'b1;
`endif
  endfunction

  // Scoreboard monitor on instance 0 (WAIT_STATES = 1)
  initial begin
    exp_t e;
    int   en_run;
    logic en_prev;
    logic ack_prev;
    en_run   = 0;
    en_prev  = 1'b0;
    ack_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        en_run   = 0;
        en_prev  = 1'b0;
        ack_prev = 1'b0;
      end else begin
        check_eq("ack_excl", 32'(if_ack[0] & dm_ack[0]), 32'd0);
        check_eq("we_without_en", 32'(mem_we[0] & ~mem_en[0]), 32'd0);
        check_eq("busy", 32'(busy[0]), 32'(mem_en[0] | if_ack[0] | dm_ack[0]));
        if (ack_prev) check_eq("idle_gap", 32'(busy[0]), 32'd0);
        if (mem_en[0]) begin
          if (!en_prev) en_run = 0;
          en_run++;
          if (sb_q.size() == 0) begin
            check_eq("unexpected_access", 32'd1, 32'd0);
          end else begin
            e = sb_q[0];
            check_eq("grant_owner", 32'(owner[0]), 32'(e.dm));
            check_eq("mem_addr", mem_addr[0], e.addr);
            check_eq("mem_we", 32'(mem_we[0]), 32'(e.we));
            if (e.we) check_eq("mem_wdata", mem_wdata[0], e.data);
          end
        end else if (en_prev) begin
          check_eq("access_len", 32'(en_run), 32'd2);
        end
        if (if_ack[0] || dm_ack[0]) begin
          if (sb_q.size() == 0) begin
            check_eq("unexpected_ack", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check_eq("ack_owner", 32'(dm_ack[0]), 32'(e.dm));
            if (!e.we) begin
              if (e.dm) exp_dm_rd = e.data;
              else      exp_if_rd = e.data;
            end
          end
        end
        check_eq("if_rdata", if_rdata[0], exp_if_rd);
        check_eq("dm_rdata", dm_rdata[0], exp_dm_rd);
        en_prev  = mem_en[0];
        ack_prev = if_ack[0] | dm_ack[0];
      end
    end
  end

  task automatic serve_if(input logic [AW-1:0] a);
    bit seen = 0;
    if_addr[0] = a;
    if_req[0]  = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clock);
      if (mem_en[0] && !owner[0]) if_addr[0] = ~a;
      if (if_ack[0]) seen = 1;
    end
    if_req[0] = 1'b0;
    check_eq("if_ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic serve_dm(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen = 0;
    dm_we[0]    = we;
    dm_addr[0]  = a;
    dm_wdata[0] = d;
    dm_req[0]   = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clock);
      if (mem_en[0] && owner[0]) begin
        dm_addr[0]  = ~a;
        dm_wdata[0] = ~d;
        dm_we[0]    = ~we;
      end
      if (dm_ack[0]) seen = 1;
    end
    dm_req[0] = 1'b0;
    dm_we[0]  = 1'b0;
    check_eq("dm_ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 60 && sb_q.size() != 0; c++) begin
      @(negedge clock);
      #1;
    end
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    @(negedge clock);
  endtask

  // Lone DM load on a bare instance; the request is dropped in the first ACCESS cycle
  task automatic run_drop(input int i, input int ws);
    int en_cnt  = 0;
    int ack_cnt = 0;
    int if_cnt  = 0;
    @(negedge clock);
    dm_we[i]   = 1'b0;
    dm_addr[i] = 32'h70;
    dm_req[i]  = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (mem_en[i]) begin
        en_cnt++;
        dm_req[i] = 1'b0;
        check_eq("drop_owner", 32'(owner[i]), 32'd1);
      end
      if (dm_ack[i]) ack_cnt++;
      if (if_ack[i]) if_cnt++;
    end
    dm_req[i] = 1'b0;
    check_eq($sformatf("drop_access_len_ws%0d", ws), 32'(en_cnt), 32'(ws + 1));
    check_eq($sformatf("drop_ack_cnt_ws%0d", ws), 32'(ack_cnt), 32'd1);
    check_eq($sformatf("drop_if_ack_ws%0d", ws), 32'(if_cnt), 32'd0);
    check_eq($sformatf("drop_rdata_ws%0d", ws), dm_rdata[i], mem_val(32'h70));
  endtask

  initial begin
    logic w;
    int   acks;
    for (int i = 0; i < NI; i++) begin
      if_req[i]   = 1'b0;
      if_addr[i]  = '0;
      dm_req[i]   = 1'b0;
      dm_we[i]    = 1'b0;
      dm_addr[i]  = '0;
      dm_wdata[i] = '0;
    end
    repeat (3) @(negedge clock);
    check_eq("rst_mem_en", 32'(mem_en[0]), 32'd0);
    check_eq("rst_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_owner", 32'(owner[0]), 32'd0);
    check_eq("rst_acks", 32'({if_ack[0], dm_ack[0]}), 32'd0);
    check_eq("rst_mem_addr", mem_addr[0], 32'd0);
    check_eq("rst_mem_wdata", mem_wdata[0], 32'd0);
    check_eq("rst_if_rdata", if_rdata[0], 32'd0);
    check_eq("rst_dm_rdata", dm_rdata[0], 32'd0);
    #1 reset_n = 1'b1;
    @(negedge clock);

    // Fetch read
    push_exp(1'b0, 1'b0, 32'h10, '0);
    serve_if(32'h10);
    wait_drain();
    check_eq("t1_if_rdata", if_rdata[0], 32'hDEADBEEF);

    // Store leaves dm_rdata untouched
    push_exp(1'b1, 1'b1, 32'h20, 32'h12345678);
    serve_dm(1'b1, 32'h20, 32'h12345678);
    wait_drain();
    check_eq("t2_dm_rdata", dm_rdata[0], 32'd0);

    // Simultaneous requests, each dropped after its own ack
    w = pick_both();
    push_exp(w, 1'b0, w ? 32'h48 : 32'h44, '0);
    push_exp(~w, 1'b0, w ? 32'h44 : 32'h48, '0);
    fork
      serve_if(32'h44);
      serve_dm(1'b0, 32'h48, '0);
    join
    wait_drain();

    // Both requests held across four grants
    for (int k = 0; k < 4; k++) begin
      w = pick_both();
      push_exp(w, 1'b0, w ? 32'h58 : 32'h54, '0);
    end
    if_addr[0] = 32'h54;
    dm_addr[0] = 32'h58;
    dm_we[0]   = 1'b0;
    if_req[0]  = 1'b1;
    dm_req[0]  = 1'b1;
    acks = 0;
    for (int c = 0; c < 100 && acks < 4; c++) begin
      @(negedge clock);
      if (if_ack[0] || dm_ack[0]) acks++;
    end
    if_req[0] = 1'b0;
    dm_req[0] = 1'b0;
    check_eq("t4_acks", 32'(acks), 32'd4);
    wait_drain();

    // Reset in the second ACCESS cycle of a load
    push_exp(1'b1, 1'b0, 32'h60, '0);
    dm_we[0]   = 1'b0;
    dm_addr[0] = 32'h60;
    dm_req[0]  = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2;
    check_eq("t5_en_before", 32'(mem_en[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    dm_req[0] = 1'b0;
    check_eq("t5_en_async", 32'(mem_en[0]), 32'd0);
    check_eq("t5_busy", 32'(busy[0]), 32'd0);
    check_eq("t5_mem_addr", mem_addr[0], 32'd0);
    check_eq("t5_dm_rdata", dm_rdata[0], 32'd0);
    check_eq("t5_if_rdata", if_rdata[0], 32'd0);
    sb_q.delete();
    exp_if_rd = '0;
    exp_dm_rd = '0;
    mdl_last  = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("t5_no_ack", 32'({if_ack[0], dm_ack[0]}), 32'd0);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_eq("t5_no_ack_after", 32'({if_ack[0], dm_ack[0]}), 32'd0);
    push_exp(1'b1, 1'b0, 32'h64, '0);
    serve_dm(1'b0, 32'h64, '0);
    wait_drain();
    check_eq("t5_dm_rdata_new", dm_rdata[0], mem_val(32'h64));

    // Dropped request still completes at both wait-state extremes
    run_drop(1, 0);
    run_drop(2, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
